// File: rtl/botrom_pkg.sv
// botrom_pkg: shared types and constants for the bottom (jump-decision) ROM loader and read side.
package botrom_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, LOAD, CHECK, DONE, ERR} state_t;
  localparam int BOTROM_ADDR_WIDTH = 12;
  localparam int BOTROM_DEPTH = 4096;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int PC_LSB = 0;
  localparam int NZVC_LSB = 8;
endpackage

// File: rtl/botrom_addr_ctr.sv
// botrom_addr_ctr: write-address counter with clear, increment and terminal-count flag.
module botrom_addr_ctr #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);
  assign tc = &count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/botrom_writer.sv
// botrom_writer: streams a sync byte plus table bytes into the bottom ROM write port.
// Define BOTROM_WRITER_CHECKSUM_EN to add the trailing checksum byte and the error outcome.
module botrom_writer
  import botrom_pkg::*;
#(
  parameter int         ADDR_WIDTH = BOTROM_ADDR_WIDTH,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
`ifdef BOTROM_WRITER_CHECKSUM_EN
  localparam state_t LOAD_EXIT = CHECK;
  logic [7:0] sum;
`else
  localparam state_t LOAD_EXIT = DONE;
`endif
  state_t state;
  logic [ADDR_WIDTH-1:0] count;
  logic tc, accept, inc;
  assign in_ready = state inside {SYNC, LOAD, CHECK};
  assign busy = in_ready;
  assign done = state == DONE;
`ifdef BOTROM_WRITER_CHECKSUM_EN
  assign error = state == ERR;
`else
  assign error = 1'b0;
`endif
  assign accept = in_valid && in_ready;
  // start takes priority, so a byte arriving with it never reaches the ROM
  assign inc = accept && !start && state == LOAD;
  botrom_addr_ctr #(.W(ADDR_WIDTH)) u_ctr (
    .clk(clk), .reset_n(reset_n), .clr(start), .inc(inc), .count(count), .tc(tc)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef BOTROM_WRITER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      wr_en <= inc;
      if (inc) begin
        wr_addr <= count;
        wr_data <= in_data;
      end
      if (start) begin
        state <= SYNC;
`ifdef BOTROM_WRITER_CHECKSUM_EN
        sum <= '0;
`endif
      end else if (accept) begin
        if (state == SYNC && in_data == SYNC_BYTE) state <= LOAD;
        if (state == LOAD && tc) state <= LOAD_EXIT;
`ifdef BOTROM_WRITER_CHECKSUM_EN
        if (state == LOAD) sum <= sum + in_data;
        if (state == CHECK) state <= 8'(sum + in_data) == 8'd0 ? DONE : ERR;
`endif
      end
    end
endmodule

// File: tb/tb_botrom_writer.sv
// tb_botrom_writer: directed bench with a write scoreboard for botrom_writer.
// Honours BOTROM_WRITER_CHECKSUM_EN the same way as the design.
module tb_botrom_writer;
  logic clk = 0, reset_n = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = '0;
  logic in_ready, wr_en, busy, done, error;
  logic [11:0] wr_addr;
  logic [7:0] wr_data;
  int n_asserts = 0, n_fail = 0, n_writes = 0, w0;
  logic [19:0] exp_q[$];
  logic [19:0] e;

  botrom_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every ROM write must match the oldest expected (addr, data) pair
  always @(negedge clk)
    if (reset_n && wr_en) begin
      n_writes++;
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[19:8]));
        chk("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1;
    in_data = b;
    tick();
    in_valid = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic full_load(input logic [7:0] csum);
    logic [11:0] a;
    do_start();
    send(8'hA5);
    for (int i = 0; i < 4096; i++) begin
      a = 12'(i);
      exp_q.push_back({a, a[7:0]});
      send(a[7:0]);
    end
`ifdef BOTROM_WRITER_CHECKSUM_EN
    send(csum);
`else
    if (csum != 8'h00) $display("checksum byte %0h not sent in this build", csum);
`endif
    repeat (3) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    #20;
    reset_n = 1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 0);
    // noise before sync: only 0x42 is written
    w0 = n_writes;
    do_start();
    chk("sync_busy", 32'(busy), 1);
    chk("sync_in_ready", 32'(in_ready), 1);
    send(8'h00); send(8'h5A); send(8'hA5);
    exp_q.push_back({12'h000, 8'h42});
    send(8'h42);
    repeat (2) tick();
    chk("noise_writes", 32'(n_writes - w0), 1);
    // restart with a simultaneous accepted byte
    w0 = n_writes;
    do_start();
    send(8'hA5);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({12'(i), 8'(8'h30 + i)});
      send(8'(8'h30 + i));
    end
    start = 1;
    send(8'h99);
    start = 0;
    chk("restart_busy", 32'(busy), 1);
    send(8'hA5);
    exp_q.push_back({12'h000, 8'h77});
    send(8'h77);
    repeat (2) tick();
    chk("restart_writes", 32'(n_writes - w0), 11);
    chk("restart_done", 32'(done), 0);
    // asynchronous reset mid-load at count 0x123
    do_start();
    send(8'hA5);
    for (int i = 0; i < 12'h123; i++) begin
      exp_q.push_back({12'(i), 8'(i)});
      send(8'(i));
    end
    tick();
    #2;
    reset_n = 0;
    #1;
    chk_all_zero("async_reset");
    chk("async_reset_queue", 32'(exp_q.size()), 0);
    #10;
    reset_n = 1;
    tick();
    chk("post_reset_in_ready", 32'(in_ready), 0);
    chk("post_reset_busy", 32'(busy), 0);
    // full good load, data sum is 0x00
    w0 = n_writes;
    full_load(8'h00);
    chk("full_writes", 32'(n_writes - w0), 4096);
    chk("full_queue", 32'(exp_q.size()), 0);
    chk("full_last_addr", 32'(wr_addr), 32'hFFF);
    chk("full_last_data", 32'(wr_data), 32'hFF);
    chk("full_done", 32'(done), 1);
    chk("full_error", 32'(error), 0);
    chk("full_busy", 32'(busy), 0);
    chk("full_in_ready", 32'(in_ready), 0);
`ifdef BOTROM_WRITER_CHECKSUM_EN
    w0 = n_writes;
    full_load(8'h01);
    chk("bad_writes", 32'(n_writes - w0), 4096);
    chk("bad_error", 32'(error), 1);
    chk("bad_done", 32'(done), 0);
    do_start();
    chk("bad_error_clear", 32'(error), 0);
`else
    do_start();
`endif
    chk("restart_done_clear", 32'(done), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/botrom_writer.md
# botrom_writer

Loader that fills the 4096-entry bottom (jump-decision) ROM from a byte stream. It sits between a byte source (UART receiver or bench) and the ROM's write port, and produces one write per accepted data byte. Write addresses follow the ROM read mapping: bits [7:0] = PC and bits [11:8] = NZVC. The PC field increments fastest.

## Interface
- ADDR_WIDTH, 12, ROM address width; the table holds 1 << ADDR_WIDTH bytes.
- SYNC_BYTE, 8'hA5, header byte that opens a load.

- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  reset; asynchronous and active-low.
- start  in  1  single-cycle request to begin, or restart, a load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- wr_en  out  1  ROM write strobe, one cycle per byte.
- wr_addr  out  ADDR_WIDTH  ROM write address; [7:0] = PC, [11:8] = NZVC.
- wr_data  out  8  ROM write data.
- busy  out  1  a load is in progress (SYNC, LOAD or CHECK).
- done  out  1  load completed successfully; held until the next start.
- error  out  1  checksum mismatch; held until the next start.

## Operation
- Transfer: a byte is accepted when in_valid && in_ready are both high on a clock edge. in_ready is decoded from the state register only.
  - in_ready = 1 in SYNC, LOAD and CHECK.
  - in_ready = 0 in IDLE, DONE and ERR.
- States:
  - IDLE: start moves to SYNC.
  - SYNC: accepted SYNC_BYTE moves to LOAD. Any other accepted byte is discarded and the block stays in SYNC.
  - LOAD: each accepted byte is written at the current count, then the count increments. Acceptance at count 0xFFF moves to CHECK when CHECKSUM_EN is defined, otherwise to DONE.
  - CHECK: one accepted byte. If (sum + byte) mod 256 == 0, go to DONE, else go to ERR.
  - DONE / ERR: hold. start moves to SYNC.
- Counter:
  - 12-bit, cleared on every entry to SYNC.
  - Wraps 0xFFF -> 0x000 only at the LOAD exit; no further writes occur after the wrap.
- Sum: 8-bit modulo-256 accumulator of LOAD bytes, cleared on entry to SYNC.
- Restart: start in SYNC, LOAD or CHECK aborts the load and moves to SYNC; counter and sum clear. ROM contents already written stay in place.
- Simultaneous start and an accepted byte: start wins and the byte is dropped. The wr_en pulse for the previous cycle's byte still issues.
- done and error are never high together. Both clear on the cycle the block leaves DONE or ERR.

## Timing
- Reset values: state IDLE, counter 0, sum 0, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, error 0.
- Write latency: a byte accepted at edge N appears as wr_en/wr_addr/wr_data during cycle N+1. These outputs are registered; wr_addr and wr_data hold their last value when wr_en = 0.
- Throughput: one byte per clock. A full load with checksum takes 1 sync + 4096 data + 1 check bytes, so 4098 accepts minimum.
- done or error rises the cycle after the final accept.
- Asserting reset_n low mid-load returns every output to its reset value immediately, without waiting for a clock edge.

## Configuration
- BOTROM_WRITER_CHECKSUM_EN defined:
  - CHECK state and sum accumulator are present.
  - Stream is 4098 bytes.
  - error is reachable.
- Not defined:
  - No CHECK state and no accumulator.
  - LOAD goes straight to DONE.
  - error is tied to 0.

## Structure
- Shared package botrom_pkg holds:
  - state enum (IDLE, SYNC, LOAD, CHECK, DONE, ERR);
  - BOTROM_ADDR_WIDTH = 12;
  - BOTROM_DEPTH = 4096;
  - SYNC_BYTE default 8'hA5;
  - field positions PC_LSB = 0 and NZVC_LSB = 8, shared with the ROM read side.
- Sub-module botrom_addr_ctr holds the 12-bit counter with clear, increment and terminal-count flag. The FSM, accumulator and output registers stay at top level.

## Test plan
- Reset mid-LOAD at count 0x123: reset_n low -> all outputs 0 asynchronously; after release the state is IDLE and in_ready = 0.
- Full load: start, A5, byte i = i[7:0] for i = 0..4095, checksum 0x00 (the data sum is 0x00) -> 4096 wr_en pulses, the last at wr_addr 0xFFF with wr_data 0xFF; done = 1, error = 0.
- Address mapping: data byte 0x1FF -> wr_addr 0x1FF (NZVC = 1, PC = 0xFF), confirming PC increments fastest.
- Bad checksum (CHECKSUM_EN defined): same load with checksum 0x01 -> error = 1, done = 0, no 4097th write.
- Noise before sync: start, then 0x00, 0x5A, 0xA5, 0x42 -> exactly one wr_en, at wr_addr 0x000 with wr_data 0x42.
- Restart: start, A5, 10 data bytes; then start in the same cycle as an accepted byte -> that byte is dropped, busy stays 1, and the next A5 + 0x77 writes 0x77 at wr_addr 0x000.
